// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: decode-register handshake between fetch/decode and execute
//   master (fetch)  : drives dec_valid and the decoded fields, samples ex_ready
//   slave (execute) : samples dec_valid and the decoded fields, drives ex_ready
//   transfer happens on a clock edge where dec_valid & ex_ready
interface instr_fetch_decode_if #(parameter int ADDR_W = 8);
    logic              dec_valid;
    logic              ex_ready;
    logic [3:0]        dec_opcode;
    logic [2:0]        dec_func;
    logic [1:0]        dec_src_ty;
    logic [7:0]        dec_src_val;
    logic [1:0]        dec_dst_ty;
    logic [7:0]        dec_dst_val;
    logic [7:0]        dec_imm;
    logic [ADDR_W-1:0] dec_pc;
    modport master (
        output dec_valid, dec_opcode, dec_func, dec_src_ty, dec_src_val,
               dec_dst_ty, dec_dst_val, dec_imm, dec_pc,
        input  ex_ready
    );
    modport slave (
        input  dec_valid, dec_opcode, dec_func, dec_src_ty, dec_src_val,
               dec_dst_ty, dec_dst_val, dec_imm, dec_pc,
        output ex_ready
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: program counter, ROM fetch, JMP/ATC resolution and decode register
//   clk, rst_n : clock, async active-low reset
//   run        : fetch enable (0 freezes PC and FSM; decode register still drains)
//   rom_addr   : program memory address (= PC)
//   rom_data   : program memory word, combinational from rom_addr
//   flags      : datapath flags tested by ATC
//   ex_idle    : execute has nothing in flight, flags are final
//   flag_clr   : one-cycle one-hot clear of the flag taken by ATC
//   dec        : decode register handshake towards execute
module instr_fetch_decode #(
    parameter int         ADDR_W   = 8,
    parameter int         INSTR_W  = 35,
    parameter int         RESET_PC = 0,
    parameter int         FLAG_W   = 8,
    parameter logic [3:0] OP_JMP   = 4'hE,
    parameter logic [3:0] OP_ATC   = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0]   rom_data,
    input  logic [FLAG_W-1:0]    flags,
    input  logic                 ex_idle,
    output logic [FLAG_W-1:0]    flag_clr,
    instr_fetch_decode_if.master dec
);
    typedef enum logic [1:0] {S_START, S_RUN, S_WAIT} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, target;
    logic [FLAG_W-1:0] flag_clr_nxt;
    logic [3:0]        op;
    logic [2:0]        bit_sel;
    logic              fire, load, jmp_go, atc_go, taken, valid_nxt;
    assign rom_addr = pc;
    assign op       = rom_data[34:31];
    assign bit_sel  = rom_data[30:28];
    assign target   = ADDR_W'(rom_data[7:0]);
    assign pc_inc   = pc + ADDR_W'(1);
    assign taken    = flags[bit_sel];
    // fire: a word at PC is consumed this cycle (slot free and fetching)
    assign fire     = state == S_RUN && run && (!dec.dec_valid || dec.ex_ready);
    assign load     = fire && op != OP_JMP && op != OP_ATC;
    assign jmp_go   = fire && op == OP_JMP;
    // ATC resolves only once the pipeline has drained so the flag value is final
    assign atc_go   = state == S_WAIT && run && !dec.dec_valid && ex_idle;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_START;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == S_START           ? S_RUN  :
                    (fire && op == OP_ATC)     ? S_WAIT :
                    atc_go                     ? S_RUN  : state;
    end
    always_comb begin
        pc_nxt       = load   ? pc_inc :
                       jmp_go ? target :
                       atc_go ? (taken ? target : pc_inc) : pc;
        flag_clr_nxt = (atc_go && taken) ? FLAG_W'(1) << bit_sel : '0;
        valid_nxt    = load || (dec.dec_valid && !dec.ex_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= ADDR_W'(RESET_PC);
            flag_clr      <= '0;
            dec.dec_valid <= 1'b0;
            dec.dec_pc    <= '0;
            {dec.dec_opcode, dec.dec_func, dec.dec_src_ty, dec.dec_src_val,
             dec.dec_dst_ty, dec.dec_dst_val, dec.dec_imm} <= '0;
        end else begin
            pc            <= pc_nxt;
            flag_clr      <= flag_clr_nxt;
            dec.dec_valid <= valid_nxt;
            if (load) begin
                dec.dec_pc <= pc;
                {dec.dec_opcode, dec.dec_func, dec.dec_src_ty, dec.dec_src_val,
                 dec.dec_dst_ty, dec.dec_dst_val, dec.dec_imm} <= rom_data[34:0];
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_ATC = 4'hF;
    logic        clk = 0, rst_n = 0, run = 1, ex_idle = 1;
    logic [7:0]  rom_addr, flags = 0, flag_clr, exp_pc;
    logic [34:0] rom_data, dec_word;
    logic [34:0] rom [256];
    logic [7:0]  sb [$];
    int          tests = 0, fails = 0, pulses = 0;
    instr_fetch_decode_if #(.ADDR_W(8)) dif ();
    instr_fetch_decode #(.ADDR_W(8), .INSTR_W(35), .RESET_PC(0), .FLAG_W(8),
                         .OP_JMP(OP_JMP), .OP_ATC(OP_ATC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .flags(flags), .ex_idle(ex_idle), .flag_clr(flag_clr), .dec(dif)
    );
    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];
    assign dec_word = {dif.dec_opcode, dif.dec_func, dif.dec_src_ty, dif.dec_src_val,
                       dif.dec_dst_ty, dif.dec_dst_val, dif.dec_imm};
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // inputs only change at posedge+2, so at negedge ex_ready is the value the next edge uses
    always @(negedge clk) if (rst_n) begin
        if (flag_clr != 0) pulses++;
        if (dif.dec_valid && dif.ex_ready) begin
            if (sb.size() == 0) chk("xfer_extra", 1, 0);
            else begin
                exp_pc = sb.pop_front();
                chk("xfer_pc", dif.dec_pc, exp_pc);
                chk("xfer_fields", dec_word, rom[exp_pc]);
            end
        end
    end
    function automatic logic [34:0] plain_word();
        return {4'($urandom_range(0, 13)), 31'($urandom)};
    endfunction
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic fill_plain();
        for (int i = 0; i < 256; i++) rom[i] = plain_word();
    endtask
    task automatic go_reset(input string tag);
        rst_n = 0;
        #1;
        chk({tag, "_addr"}, rom_addr, 0);
        chk({tag, "_dv"}, dif.dec_valid, 0);
        chk({tag, "_fc"}, flag_clr, 0);
        sb.delete();
        step();
    endtask
    task automatic start();
        step();
        rst_n = 1;
        step();
        chk("settle_dv", dif.dec_valid, 0);
        chk("settle_addr", rom_addr, 0);
        step();
        chk("first_dv", dif.dec_valid, 1);
        chk("first_pc", dif.dec_pc, 0);
    endtask
    task automatic wait_pc(input logic [7:0] p);
        bit hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            if (dif.dec_valid && dif.dec_pc == p) hit = 1;
            else step();
        end
        if (!hit) chk("wait_timeout", p, 64'hdead);
    endtask
    task automatic drained();
        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
    endtask
    task automatic run_atc(input bit tk);
        fill_plain();
        rom[8] = {OP_ATC, 3'd3, 20'd0, 8'd16};
        flags = tk ? 8'h08 : 8'hF7;
        ex_idle = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) sb.push_back(8'(i));
        sb.push_back(tk ? 8'd16 : 8'd9);
        start();
        wait_pc(7);
        repeat (3) begin
            step();
            chk("atc_stall_dv", dif.dec_valid, 0);
            chk("atc_stall_addr", rom_addr, 8);
            chk("atc_stall_fc", flag_clr, 0);
        end
        ex_idle = 1;
        step();
        chk("atc_fc", flag_clr, tk ? 8'h08 : 8'h00);
        chk("atc_addr", rom_addr, tk ? 8'd16 : 8'd9);
        flags = flags & ~flag_clr;
        step();
        chk("atc_fc_off", flag_clr, 0);
        chk("atc_next_pc", dif.dec_pc, tk ? 8'd16 : 8'd9);
        drained();
        chk("atc_pulses", pulses, tk ? 1 : 0);
        go_reset("atc_rst");
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        dif.ex_ready = 1;
        fill_plain();
        rom[12] = {OP_JMP, 3'd0, 20'd0, 8'd4};
        for (int i = 0; i < 12; i++) sb.push_back(8'(i));
        sb.push_back(8'd4);
        #3;
        chk("rst_addr", rom_addr, 0);
        chk("rst_dv", dif.dec_valid, 0);
        chk("rst_fc", flag_clr, 0);
        start();
        step();
        step();
        chk("bp_pc", dif.dec_pc, 2);
        dif.ex_ready = 0;
        repeat (3) begin
            step();
            chk("bp_dv", dif.dec_valid, 1);
            chk("bp_hold_pc", dif.dec_pc, 2);
            chk("bp_hold_fields", dec_word, rom[2]);
            chk("bp_hold_addr", rom_addr, 3);
        end
        dif.ex_ready = 1;
        step();
        chk("bp_release", dif.dec_pc, 3);
        wait_pc(11);
        step();
        chk("jmp_bubble", dif.dec_valid, 0);
        chk("jmp_addr", rom_addr, 4);
        step();
        chk("jmp_dv", dif.dec_valid, 1);
        chk("jmp_pc", dif.dec_pc, 4);
        drained();
        go_reset("mid_rst");
        run_atc(1);
        run_atc(0);
        fill_plain();
        rom[1] = {OP_JMP, 3'd0, 20'd0, 8'd254};
        flags = 0;
        sb.push_back(8'd0);
        sb.push_back(8'd254);
        sb.push_back(8'd255);
        sb.push_back(8'd0);
        start();
        wait_pc(255);
        step();
        chk("wrap_dv", dif.dec_valid, 1);
        chk("wrap_pc", dif.dec_pc, 0);
        drained();
        go_reset("wrap_rst");
        fill_plain();
        rom[8] = {OP_ATC, 3'd3, 20'd0, 8'd16};
        flags = 8'h08;
        ex_idle = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) sb.push_back(8'(i));
        start();
        wait_pc(7);
        step();
        step();
        chk("wait_addr", rom_addr, 8);
        ex_idle = 1;
        #1;
        go_reset("wait_rst");
        repeat (3) begin
            step();
            chk("wait_rst_fc", flag_clr, 0);
            chk("wait_rst_dv", dif.dec_valid, 0);
        end
        chk("wait_rst_pulses", pulses, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
